// File: rtl/mdu_op_queue.sv
// mdu_op_queue: in-order FIFO of committed MDU operations feeding the
// multiply/divide unit, one issue at a time whenever the MDU is idle.
// Also produces hilo_ready, which gates mfhi/mflo.
// Optional feature macro: MDQ_DIVZERO_DROP_EN -- when defined, div/divu with
// a zero divisor are discarded at enqueue instead of being queued.
module mdu_op_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_cancel,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             req_ready,
  output logic [3:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  input  logic             mdu_busy,
  output logic             hilo_ready,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  entry_t           mem_rd [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic             op_legal;
  logic             op_dropped;
  logic             push;
  logic             pop;

  // Classify the incoming request and decide push/pop for this cycle
  always_comb begin
    op_legal   = (req_op == 4'd1) || (req_op == 4'd2) || (req_op == 4'd3) ||
                 (req_op == 4'd4) || (req_op == 4'd7) || (req_op == 4'd8);
`ifdef MDQ_DIVZERO_DROP_EN
    // A divide by zero leaves HI/LO untouched in the MDU, so never queue it
    op_dropped = ((req_op == 4'd3) || (req_op == 4'd4)) && (req_b == 32'd0);
`else
    op_dropped = 1'b0;
`endif
    // No full-bypass: a full queue refuses pushes even while popping
    req_ready  = (count_q != FULL_CNT);
    push       = req_valid & ~req_cancel & req_ready & op_legal & ~op_dropped;
    pop        = (count_q != '0) & ~mdu_busy;
    wr_entry   = '{op: req_op, a: req_a, b: req_b};
  end

  // Per-entry storage: each slot captures the request when it is the write target
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    entry_t entry_q, entry_d;

    // Next value of this slot
    always_comb begin
      entry_d = entry_q;
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        entry_d = wr_entry;
      end
    end

    // Slot register, cleared so md_a/md_b read zero out of reset
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign mem_rd[gi] = entry_q;
  end

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared immediately on reset assertion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue interface: the op code is only non-zero in a cycle where the MDU takes it
  always_comb begin
    head       = mem_rd[rd_ptr_q];
    md_op      = pop ? head.op : 4'd0;
    md_a       = head.a;
    md_b       = head.b;
    hilo_ready = (count_q == '0) & ~mdu_busy;
    count      = count_q;
  end

endmodule

// File: tb/tb_mdu_op_queue.sv
// Testbench for mdu_op_queue: directed table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model plus
// a behavioural MDU that computes HI/LO from whatever the DUT issues.
module tb_mdu_op_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_cancel;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        mdu_busy;
  logic        hilo_ready;
  logic [PTR_W:0] count;

  mdu_op_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cancel(req_cancel),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .mdu_busy(mdu_busy),
    .hilo_ready(hilo_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic        v;
    logic        c;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    int          exp_count;
    logic        exp_ready;
    logic        exp_hilo;
    logic [3:0]  exp_op;
  } vec_t;

  int errors = 0;
  int checks = 0;

  op_t   mq[$];          // reference queue contents, oldest first
  logic [31:0] hi_r = 0, lo_r = 0;
  int    busy_cnt = 0;
  logic  force_busy = 1'b0;

  logic [3:0]  obs_op;
  logic [31:0] obs_a, obs_b;
  int          obs_count;
  logic        obs_ready, obs_hilo;
  bit          obs_push;
  int          issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_accepts(input logic v, input logic c,
                                       input logic [3:0] op, input logic [31:0] b);
    bit ok;
    ok = v && !c && (mq.size() < DEPTH) && (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8});
`ifdef MDQ_DIVZERO_DROP_EN
    if ((op == 4'd3 || op == 4'd4) && b == 32'd0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Behavioural MDU: apply an accepted op to HI/LO and decide how long it is busy
  task automatic mdu_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; hi_r = p[63:32]; lo_r = p[31:0]; busy_cnt = $urandom_range(1, 3); end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; hi_r = pu[63:32]; lo_r = pu[31:0]; busy_cnt = $urandom_range(1, 3); end
      4'd3: if (b != 0) begin lo_r = 32'(sa / sb); hi_r = 32'(sa % sb); busy_cnt = $urandom_range(1, 3); end
      4'd4: if (b != 0) begin lo_r = a / b; hi_r = a % b; busy_cnt = $urandom_range(1, 3); end
      4'd7: hi_r = a;
      4'd8: lo_r = a;
      default: ;
    endcase
  endtask

  // One clock cycle: drive at negedge, check just before posedge, update model after it
  task automatic cycle(input logic v, input logic c, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bit   exp_pop;
    logic busy_now;
    @(negedge clk);
    req_valid = v; req_cancel = c; req_op = op; req_a = a; req_b = b;
    mdu_busy = force_busy || (busy_cnt != 0);
    #4;
    busy_now  = mdu_busy;
    exp_pop   = (mq.size() != 0) && !busy_now;
    obs_op = md_op; obs_a = md_a; obs_b = md_b;
    obs_count = int'(count); obs_ready = req_ready; obs_hilo = hilo_ready;
    obs_push  = model_accepts(v, c, op, b);
    chk("count", 32'(count), 32'(mq.size()));
    chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("hilo_ready", 32'(hilo_ready), 32'((mq.size() == 0) && !busy_now));
    chk("md_op", 32'(md_op), exp_pop ? 32'(mq[0].op) : 32'd0);
    if (exp_pop) begin
      chk("md_a", md_a, mq[0].a);
      chk("md_b", md_b, mq[0].b);
    end
    $display("cyc t=%0t v=%0d c=%0d op=%0d cnt=%0d md_op=%0d busy=%0d push=%0d",
             $time, v, c, op, count, md_op, busy_now, obs_push);
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (md_op_latched(obs_op, busy_now)) begin
      issued++;
      mdu_exec(obs_op, obs_a, obs_b);
    end
    if (exp_pop) void'(mq.pop_front());
    if (obs_push) mq.push_back('{op: op, a: a, b: b});
    mdu_busy = force_busy || (busy_cnt != 0);
  endtask

  function automatic bit md_op_latched(input logic [3:0] op, input logic busy_now);
    return (op != 4'd0) && !busy_now;
  endfunction

  task automatic idle();
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mq.size() == 0 && busy_cnt == 0 && !force_busy) begin
        done = 1'b1;
        break;
      end
      idle();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] hi_save, lo_save;
    int k, guard;
    logic [3:0] op_pool[9];

    reset = 1'b0; req_valid = 0; req_cancel = 0; req_op = 0; req_a = 0; req_b = 0;
    mdu_busy = 1'b0;

    // Reset state
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_md_op", 32'(md_op), 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_md_b", md_b, 32'd0);
    chk("rst_hilo", 32'(hilo_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // mult 3 * -2 with idle MDU: issues in the next cycle
    cycle(1'b1, 1'b0, 4'd1, 32'd3, 32'hFFFF_FFFE);
    idle();
    chk("mult_issue_op", 32'(obs_op), 32'd1);
    chk("mult_issue_a", obs_a, 32'd3);
    chk("mult_issue_b", obs_b, 32'hFFFF_FFFE);
    chk("mult_hilo_low", 32'(obs_hilo), 32'd0);
    drain();
    chk("mult_hi", hi_r, 32'hFFFF_FFFF);
    chk("mult_lo", lo_r, 32'hFFFF_FFFA);

    // Fill while the MDU is busy; fifth push refused; cancelled push ignored
    vecs[0] = '{1, 0, 4'd3, 32'd7,    32'd2, 1, 0, 1, 0, 4'd0};
    vecs[1] = '{1, 0, 4'd7, 32'h55,   32'd0, 1, 1, 1, 0, 4'd0};
    vecs[2] = '{1, 0, 4'd8, 32'hAA,   32'd0, 1, 2, 1, 0, 4'd0};
    vecs[3] = '{1, 0, 4'd2, 32'd2,    32'd2, 1, 3, 1, 0, 4'd0};
    vecs[4] = '{1, 0, 4'd1, 32'd1,    32'd1, 1, 4, 0, 0, 4'd0};
    vecs[5] = '{0, 0, 4'd0, 32'd0,    32'd0, 1, 4, 0, 0, 4'd0};
    vecs[6] = '{1, 1, 4'd8, 32'h1234, 32'd0, 1, 4, 0, 0, 4'd0};
    for (int i = 0; i < 7; i++) begin
      force_busy = vecs[i].busy;
      cycle(vecs[i].v, vecs[i].c, vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_count", i), 32'(obs_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ready", i), 32'(obs_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_hilo", i), 32'(obs_hilo), 32'(vecs[i].exp_hilo));
      chk($sformatf("vec%0d_md_op", i), 32'(obs_op), 32'(vecs[i].exp_op));
    end
    force_busy = 1'b0;
    drain();
    chk("fill_hi", hi_r, 32'd0);
    chk("fill_lo", lo_r, 32'd4);

    // Cancelled mtlo with an idle queue: no push, LO unchanged
    lo_save = lo_r;
    cycle(1'b1, 1'b1, 4'd8, 32'h1234, 32'd0);
    idle();
    chk("cancel_count", 32'(obs_count), 32'd0);
    drain();
    chk("cancel_lo", lo_r, lo_save);

    // Wrap-around: 10 mthi/mtlo ops through a full queue with simultaneous push/pop
    issued = 0;
    force_busy = 1'b1;
    k = 0;
    guard = 0;
    while (k < 10 && guard < 100) begin
      if (k >= 4) force_busy = 1'b0;
      cycle(1'b1, 1'b0, (k % 2) ? 4'd8 : 4'd7, 32'(32'h100 + k), 32'd0);
      if (obs_push) k++;
      guard++;
    end
    chk("wrap_pushed", 32'(k), 32'd10);
    force_busy = 1'b0;
    drain();
    chk("wrap_issued", 32'(issued), 32'd10);
    chk("wrap_hi", hi_r, 32'h108);
    chk("wrap_lo", lo_r, 32'h109);

    // divu with zero divisor
    hi_save = hi_r; lo_save = lo_r;
    cycle(1'b1, 1'b0, 4'd4, 32'd9, 32'd0);
    idle();
`ifdef MDQ_DIVZERO_DROP_EN
    chk("divz_count", 32'(obs_count), 32'd0);
    chk("divz_md_op", 32'(obs_op), 32'd0);
`else
    chk("divz_count", 32'(obs_count), 32'd1);
    chk("divz_md_op", 32'(obs_op), 32'd4);
`endif
    drain();
    chk("divz_hi", hi_r, hi_save);
    chk("divz_lo", lo_r, lo_save);

    // Randomized traffic against the reference model
    op_pool = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd5, 4'd15};
    for (int i = 0; i < 400; i++) begin
      logic        rv, rc;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rv  = ($urandom_range(0, 9) < 6);
      rc  = ($urandom_range(0, 9) == 0);
      rop = op_pool[$urandom_range(0, 8)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cycle(rv, rc, rop, ra, rb);
    end
    drain();

    // Asynchronous reset in the middle of a non-empty queue
    force_busy = 1'b1;
    cycle(1'b1, 1'b0, 4'd7, 32'd1, 32'd0);
    cycle(1'b1, 1'b0, 4'd8, 32'd2, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    chk("async_rst_md_a", md_a, 32'd0);
    mq.delete();
    busy_cnt = 0;
    force_busy = 1'b0;
    mdu_busy = 1'b0;
    #1;
    chk("async_rst_hilo", 32'(hilo_ready), 32'd1);
    chk("async_rst_md_op", 32'(md_op), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 4'd8, 32'h77, 32'd0);
    drain();
    chk("post_rst_lo", lo_r, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
